dual_writeback_regfile: RTL and testbench
=========================================

Name: dual_writeback_regfile

Overview:
- Writeback-stage consumer of the two-lane MEM/WB pipeline register in the dual-issue core.
- Per lane, selects the writeback result from ALU result, load data or PC+4, and commits it to a 32x32 architectural register file with two write ports.
- Serves four combinational read ports to decode (two per lane), with same-cycle write-through bypass.
- Presents the selected results to the hazard/forwarding unit.

Parameters:
- NREGS, 32, number of architectural registers; register index width is clog2(NREGS) = 5.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- RegWriteW1  in  1  lane-1 write enable.
- ResultSrcW1  in  2  lane-1 result select.
- ALUResultW1  in  XLEN  lane-1 ALU result.
- ReadDataW1  in  XLEN  lane-1 load data.
- PCPlus4W1  in  XLEN  lane-1 PC+4.
- RdW1  in  5  lane-1 destination register.
- RegWriteW2, ResultSrcW2, ALUResultW2, ReadDataW2, PCPlus4W2, RdW2  in  as lane 1  lane-2 equivalents.
- RS1D1, RS2D1, RS1D2, RS2D2  in  5  decode read addresses (lane 1 and lane 2).
- RD1D1, RD2D1, RD1D2, RD2D2  out  XLEN  read data for the matching address port.
- ResultW1, ResultW2  out  XLEN  selected writeback value per lane, for forwarding.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1, at the next posedge every register (x0..x31) clears to 0.
- Reset dominance: any write presented in the same cycle as rst is discarded.
- Read ports during reset: all four read data outputs return 0 while rst=1.
- Result mux (combinational, per lane):
  - ResultSrc 00 -> ALUResult
  - 01 -> ReadData
  - 10 -> PCPlus4
  - 11 -> ALUResult (reserved)
- ResultW1/ResultW2 always show the mux output, independent of RegWrite.
- Write: at posedge, when rst=0, RegWriteWn=1 and RdWn!=0, reg[RdWn] <= ResultWn. Write latency is 1 cycle.
- x0: never written. Any read of address 0 returns 0, bypass included.
- Write-write conflict: both lanes enabled with RdW1==RdW2!=0 -> lane 2 (program-younger) value is stored and lane 1 is dropped.
- Read (combinational, zero latency), per port with address A:
  - A==0 -> 0
  - else if RegWriteW2 && RdW2==A -> ResultW2
  - else if RegWriteW1 && RdW1==A -> ResultW1
  - else reg[A]
- The bypass gives same-cycle write-then-read semantics; lane 2 has priority, consistent with the write conflict rule.
- No stall or enable inputs. Upstream gating is done by the MEM/WB register, which drives RegWrite=0 for bubbles.
- Storage holds its value whenever no qualifying write occurs.

Decomposition:
- Shared package: result-select encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10; XLEN; register index width.
- One natural sub-module, writeback_result_mux, instantiated once per lane. Pure combinational; the 4:1 select above.
- Storage array, write logic and bypass logic stay in the top module.

Test Plan:
- Reset: rst=1 for 1 cycle after random writes -> all 32 registers read 0. A write of 0xDEADBEEF to x5 coincident with rst -> x5 reads 0 afterwards.
- Single lane, all sources:
  - lane 1 RegWrite=1, Rd=x3, ResultSrc=01, ReadData=0x12345678 -> RD1D1 (RS1D1=x3) = 0x12345678 the same cycle (bypass) and after the edge (stored).
  - Repeat with ResultSrc=10, PCPlus4=0x00000104 -> 0x00000104.
- x0 protection: both lanes write Rd=0 with 0xFFFFFFFF -> all ports addressing x0 read 0, now and after the edge.
- Write conflict: lane 1 writes x7=0x1111, lane 2 writes x7=0x2222 in the same cycle -> bypass reads 0x2222; after the edge x7=0x2222.
- Dual independent writes: lane 1 x10=0xA, lane 2 x11=0xB -> next cycle RD1D2 (RS1D2=x10)=0xA and RD2D2 (RS2D2=x11)=0xB. RegWrite=0 on both lanes with valid data -> no register changes.

Source files
------------

// File: rtl/dual_writeback_regfile_pkg.sv
// Shared encodings and sizes for the dual-lane writeback stage and its
// architectural register file.
package dual_writeback_regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  // Result-select encoding driven by the MEM/WB register; 2'b11 is reserved
  // and falls back to the ALU result.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

endpackage

// File: rtl/dual_writeback_regfile_result_mux.sv
// Per-lane writeback result select: ALU result, load data or PC+4.
// Purely combinational; instantiated once per lane.
module writeback_result_mux
  import dual_writeback_regfile_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [1:0]   result_src,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] read_data,
  input  logic [W-1:0] pc_plus4,
  output logic [W-1:0] result
);

  always_comb begin
    result = alu_result;
    case (result_src_e'(result_src))
      RES_MEM:           result = read_data;
      RES_PC4:           result = pc_plus4;
      RES_ALU, RES_RSVD: result = alu_result;
      default:           result = alu_result;
    endcase
  end

endmodule

// File: rtl/dual_writeback_regfile.sv
// Two-lane writeback stage: result select per lane, 32-entry register file
// with two write ports and four read ports with same-cycle write-through.
module dual_writeback_regfile
  import dual_writeback_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW1,
  input  logic [1:0]        ResultSrcW1,
  input  logic [XLEN-1:0]   ALUResultW1,
  input  logic [XLEN-1:0]   ReadDataW1,
  input  logic [XLEN-1:0]   PCPlus4W1,
  input  logic [REG_AW-1:0] RdW1,
  input  logic              RegWriteW2,
  input  logic [1:0]        ResultSrcW2,
  input  logic [XLEN-1:0]   ALUResultW2,
  input  logic [XLEN-1:0]   ReadDataW2,
  input  logic [XLEN-1:0]   PCPlus4W2,
  input  logic [REG_AW-1:0] RdW2,
  input  logic [REG_AW-1:0] RS1D1,
  input  logic [REG_AW-1:0] RS2D1,
  input  logic [REG_AW-1:0] RS1D2,
  input  logic [REG_AW-1:0] RS2D2,
  output logic [XLEN-1:0]   RD1D1,
  output logic [XLEN-1:0]   RD2D1,
  output logic [XLEN-1:0]   RD1D2,
  output logic [XLEN-1:0]   RD2D2,
  output logic [XLEN-1:0]   ResultW1,
  output logic [XLEN-1:0]   ResultW2
);

  logic [XLEN-1:0]   regs  [NREGS];
  logic [REG_AW-1:0] raddr [4];
  logic [XLEN-1:0]   rdata [4];

  writeback_result_mux #(.W(XLEN)) u_mux_lane1 (
    .result_src (ResultSrcW1),
    .alu_result (ALUResultW1),
    .read_data  (ReadDataW1),
    .pc_plus4   (PCPlus4W1),
    .result     (ResultW1)
  );

  writeback_result_mux #(.W(XLEN)) u_mux_lane2 (
    .result_src (ResultSrcW2),
    .alu_result (ALUResultW2),
    .read_data  (ReadDataW2),
    .pc_plus4   (PCPlus4W2),
    .result     (ResultW2)
  );

  // Lane 2 is program-younger: its write is issued last so it wins a
  // same-register conflict. x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (RegWriteW1 && (RdW1 != '0)) regs[RdW1] <= ResultW1;
      if (RegWriteW2 && (RdW2 != '0)) regs[RdW2] <= ResultW2;
    end
  end

  assign raddr[0] = RS1D1;
  assign raddr[1] = RS2D1;
  assign raddr[2] = RS1D2;
  assign raddr[3] = RS2D2;

  // Bypass priority mirrors the write-conflict rule so a read always sees
  // the value the register will hold after this edge.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[p] = regs[raddr[p]];
      if (rst || (raddr[p] == '0))                  rdata[p] = '0;
      else if (RegWriteW2 && (RdW2 == raddr[p]))    rdata[p] = ResultW2;
      else if (RegWriteW1 && (RdW1 == raddr[p]))    rdata[p] = ResultW1;
    end
  end

  assign RD1D1 = rdata[0];
  assign RD2D1 = rdata[1];
  assign RD1D2 = rdata[2];
  assign RD2D2 = rdata[3];

endmodule

// File: tb/tb_dual_writeback_regfile.sv
// Randomized and directed bench for dual_writeback_regfile against an
// array-based model of the architectural register state.
module tb_dual_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we1, we2;
  logic [1:0]  src1, src2;
  logic [31:0] alu1, mem1, pc1, alu2, mem2, pc2;
  logic [4:0]  rd1, rd2;
  logic [4:0]  ra [4];
  logic [31:0] rd1d1, rd2d1, rd1d2, rd2d2, res1, res2;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          n_total = 0;
  int          n_pass  = 0;

  // Clock / reset
  always #5 clk = ~clk;

  dual_writeback_regfile dut (
    .clk(clk), .rst(rst),
    .RegWriteW1(we1), .ResultSrcW1(src1), .ALUResultW1(alu1),
    .ReadDataW1(mem1), .PCPlus4W1(pc1), .RdW1(rd1),
    .RegWriteW2(we2), .ResultSrcW2(src2), .ALUResultW2(alu2),
    .ReadDataW2(mem2), .PCPlus4W2(pc2), .RdW2(rd2),
    .RS1D1(ra[0]), .RS2D1(ra[1]), .RS1D2(ra[2]), .RS2D2(ra[3]),
    .RD1D1(rd1d1), .RD2D1(rd2d1), .RD1D2(rd1d2), .RD2D2(rd2d2),
    .ResultW1(res1), .ResultW2(res2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] a,
                                       input logic [31:0] m, input logic [31:0] p);
    if (s == 2'd1) return m;
    if (s == 2'd2) return p;
    return a;
  endfunction

  // Driver tasks
  task automatic drive_lane(input int lane, input logic we, input logic [1:0] src,
                            input logic [31:0] a, input logic [31:0] m,
                            input logic [31:0] p, input logic [4:0] rd);
    if (lane == 1) begin we1 = we; src1 = src; alu1 = a; mem1 = m; pc1 = p; rd1 = rd; end
    else           begin we2 = we; src2 = src; alu2 = a; mem2 = m; pc2 = p; rd2 = rd; end
  endtask

  task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [4:0] a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
  endtask

  task automatic idle();
    drive_lane(1, 1'b0, 2'd0, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    drive_lane(2, 1'b0, 2'd0, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
  endtask

  // One clock: predict, check combinational outputs mid-cycle, then commit.
  task automatic step(input string tag);
    logic [31:0] nxt [32];
    logic [31:0] r1, r2;
    logic [31:0] obs [6];
    @(negedge clk);
    r1 = pick(src1, alu1, mem1, pc1);
    r2 = pick(src2, alu2, mem2, pc2);
    nxt = model;
    if (we1 && rd1 != 0) nxt[rd1] = r1;
    if (we2 && rd2 != 0) nxt[rd2] = r2;
    for (int p = 0; p < 4; p++)
      exp_q.push_back((rst || ra[p] == 0) ? 32'h0 : nxt[ra[p]]);
    exp_q.push_back(r1);
    exp_q.push_back(r2);
    obs[0] = rd1d1; obs[1] = rd2d1; obs[2] = rd1d2; obs[3] = rd2d2;
    obs[4] = res1;  obs[5] = res2;
    check({tag, ".RD1D1"}, obs[0], exp_q.pop_front());
    check({tag, ".RD2D1"}, obs[1], exp_q.pop_front());
    check({tag, ".RD1D2"}, obs[2], exp_q.pop_front());
    check({tag, ".RD2D2"}, obs[3], exp_q.pop_front());
    check({tag, ".ResultW1"}, obs[4], exp_q.pop_front());
    check({tag, ".ResultW2"}, obs[5], exp_q.pop_front());
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    else     model = nxt;
    #1;
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
  endfunction

  task automatic rand_lanes();
    drive_lane(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom, $urandom, $urandom, rand_reg());
    drive_lane(2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               $urandom, $urandom, $urandom, rand_reg());
    set_reads(rand_reg(), rand_reg(), rand_reg(), rand_reg());
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1;
    idle();
    set_reads(5'd0, 5'd1, 5'd2, 5'd3);
    step("reset0");
    step("reset1");
    rst = 1'b0;

    // Fill with random writes, then reset and scan every register.
    for (int i = 0; i < 20; i++) begin rand_lanes(); step("prefill"); end
    idle();
    rst = 1'b1;
    step("reset_pulse");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_reads(5'(4*i), 5'(4*i+1), 5'(4*i+2), 5'(4*i+3));
      step("reset_scan");
    end

    // Write coincident with reset is discarded.
    rst = 1'b1;
    drive_lane(1, 1'b1, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5);
    set_reads(5'd5, 5'd5, 5'd5, 5'd5);
    step("rst_write");
    rst = 1'b0;
    idle();
    step("rst_write_after");

    // Load data and PC+4 sources, bypass then stored.
    drive_lane(1, 1'b1, 2'd1, 32'h0BAD0BAD, 32'h12345678, 32'h0, 5'd3);
    set_reads(5'd3, 5'd0, 5'd3, 5'd4);
    step("mem_bypass");
    idle();
    step("mem_stored");
    drive_lane(1, 1'b1, 2'd2, 32'h0BAD0BAD, 32'h0, 32'h00000104, 5'd3);
    step("pc4_bypass");
    idle();
    step("pc4_stored");

    // x0 protection from both lanes.
    drive_lane(1, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0);
    drive_lane(2, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0);
    set_reads(5'd0, 5'd0, 5'd0, 5'd0);
    step("x0_write");
    idle();
    step("x0_after");

    // Write-write conflict: lane 2 wins.
    drive_lane(1, 1'b1, 2'd0, 32'h1111, 32'h0, 32'h0, 5'd7);
    drive_lane(2, 1'b1, 2'd3, 32'h2222, 32'h0, 32'h0, 5'd7);
    set_reads(5'd7, 5'd7, 5'd7, 5'd7);
    step("conflict_bypass");
    idle();
    step("conflict_stored");

    // Independent writes, then disabled writes leave state untouched.
    drive_lane(1, 1'b1, 2'd0, 32'hA, 32'h0, 32'h0, 5'd10);
    drive_lane(2, 1'b1, 2'd0, 32'hB, 32'h0, 32'h0, 5'd11);
    set_reads(5'd1, 5'd2, 5'd10, 5'd11);
    step("dual_write");
    idle();
    step("dual_stored");
    drive_lane(1, 1'b0, 2'd0, 32'h55, 32'h55, 32'h55, 5'd10);
    drive_lane(2, 1'b0, 2'd1, 32'h66, 32'h66, 32'h66, 5'd11);
    step("no_write");
    idle();
    step("no_write_after");

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      rand_lanes();
      rst = ($urandom_range(0, 49) == 0);
      step("random");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
